// File: rtl/mac_result_drain.sv
// Snapshots N signed accumulators on start, then streams them out as requantized,
// saturated OUT_W-bit beats over a ready/valid interface.
module mac_result_drain #(
  parameter int unsigned N      = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 8,
  localparam int unsigned LANE_W = $clog2(N),
  localparam int unsigned SH_W   = $clog2(ACC_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [SH_W-1:0]      shift_i,
  input  logic [N*ACC_W-1:0]   acc_i,
  output logic                 mac_clr_o,
  output logic                 busy_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [OUT_W-1:0]     data_o,
  output logic                 sat_o,
  output logic [LANE_W-1:0]    lane_o,
  output logic                 last_o,
  output logic                 done_o
);

  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] Q_MAX = EXT_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] Q_MIN = EXT_W'(-(2 ** (OUT_W - 1)));
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);

  typedef enum logic [1:0] {IDLE, PREP, SEND} state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   shadow_q [N];
  logic [SH_W-1:0]    shift_q;
  logic [LANE_W-1:0]  idx_q;
  logic               mac_clr_q;
  logic               busy_q;
  logic               valid_q;
  logic [OUT_W-1:0]   data_q;
  logic               sat_q;
  logic [LANE_W-1:0]  lane_q;
  logic               last_q;
  logic               done_q;

  logic [LANE_W-1:0]  sel_d;
  logic [OUT_W-1:0]   qdata_d;
  logic               qsat_d;

  // Round-half-up arithmetic shift in a 33-bit domain, then clamp to the signed output range.
  function automatic logic [OUT_W:0] requant(input logic [ACC_W-1:0] x,
                                             input logic [SH_W-1:0]  s);
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] r;
    ext = $signed({x[ACC_W-1], x});
    rnd = (s == '0) ? '0 : $signed(EXT_W'(1) << (s - SH_W'(1)));
    r   = (ext + rnd) >>> s;
    if (r > Q_MAX)      requant = {1'b1, Q_MAX[OUT_W-1:0]};
    else if (r < Q_MIN) requant = {1'b1, Q_MIN[OUT_W-1:0]};
    else                requant = {1'b0, r[OUT_W-1:0]};
  endfunction

  // One shared requantizer: lane 0 while preparing, the following lane while sending.
  always_comb begin
    sel_d            = (state_q == SEND) ? idx_q + LANE_W'(1) : '0;
    {qsat_d, qdata_d} = requant(shadow_q[sel_d], shift_q);
  end

  // Snapshot is unreset; its contents only matter after an accepted start.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start_i) begin
      for (int k = 0; k < int'(N); k++) begin
        shadow_q[k] <= acc_i[k*ACC_W +: ACC_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      mac_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      sat_q     <= 1'b0;
      lane_q    <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            shift_q   <= shift_i;
            idx_q     <= '0;
            mac_clr_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= PREP;
          end
        end
        PREP: begin
          data_q    <= qdata_d;
          sat_q     <= qsat_d;
          lane_q    <= '0;
          last_q    <= (N == 1);
          valid_q   <= 1'b1;
          mac_clr_q <= 1'b0;
          state_q   <= SEND;
        end
        SEND: begin
          if (valid_q && ready_i) begin
            if (idx_q == LAST_LANE) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              idx_q  <= sel_d;
              data_q <= qdata_d;
              sat_q  <= qsat_d;
              lane_q <= sel_d;
              last_q <= (sel_d == LAST_LANE);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mac_clr_o = mac_clr_q;
  assign busy_o    = busy_q;
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign sat_o     = sat_q;
  assign lane_o    = lane_q;
  assign last_o    = last_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_mac_result_drain.sv
// Scoreboard bench for mac_result_drain: directed drains push expected beats,
// an independent monitor pops and compares on every handshake.
module tb_mac_result_drain;

  localparam int N      = 8;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 8;
  localparam int LANE_W = 3;

  typedef struct packed {
    logic signed [OUT_W-1:0] data;
    logic                    sat;
    logic [LANE_W-1:0]       lane;
    logic                    last;
  } beat_t;

  logic               clk;
  logic               rst;
  logic               start_i;
  logic [4:0]         shift_i;
  logic [N*ACC_W-1:0] acc_i;
  logic               mac_clr_o;
  logic               busy_o;
  logic               valid_o;
  logic               ready_i;
  logic [OUT_W-1:0]   data_o;
  logic               sat_o;
  logic [LANE_W-1:0]  lane_o;
  logic               last_o;
  logic               done_o;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t       sb_q[$];
  logic [31:0] va [N];
  int          vd [N];
  bit          vs [N];
  int          pat [6] = '{1, 0, 0, 1, 0, 1};

  mac_result_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .shift_i  (shift_i),
    .acc_i    (acc_i),
    .mac_clr_o(mac_clr_o),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .sat_o    (sat_o),
    .lane_o   (lane_o),
    .last_o   (last_o),
    .done_o   (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
    end
  endtask

  // Monitor: compares each accepted beat and checks held beats under backpressure.
  bit    hold_v = 1'b0;
  beat_t hold_b;
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      cur = '{data: $signed(data_o), sat: sat_o, lane: lane_o, last: last_o};
      if (hold_v) begin
        chk("hold_valid", int'(valid_o), 1);
        chk("hold_beat", int'(cur), int'(hold_b));
        hold_v = 1'b0;
      end
      if (valid_o) begin
        if (ready_i) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_beat", int'(lane_o), -1);
          end else begin
            e = sb_q.pop_front();
            chk("beat_data", int'($signed(data_o)), int'(e.data));
            chk("beat_sat", int'(sat_o), int'(e.sat));
            chk("beat_lane", int'(lane_o), int'(e.lane));
            chk("beat_last", int'(last_o), int'(e.last));
          end
        end else begin
          hold_v = 1'b1;
          hold_b = cur;
        end
      end
    end
  end

  task automatic push_exp();
    for (int k = 0; k < N; k++) begin
      sb_q.push_back('{data: 8'(vd[k]), sat: vs[k], lane: 3'(k), last: (k == N - 1)});
    end
  endtask

  task automatic load_acc();
    for (int k = 0; k < N; k++) acc_i[k*ACC_W +: ACC_W] = va[k];
  endtask

  // One full drain; bp selects the ready pattern, poke holds start high mid-drain.
  task automatic run_drain(input logic [4:0] sh, input bit bp, input bit poke);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    load_acc();
    shift_i = sh;
    start_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    acc_i   = ~acc_i;
    shift_i = ~sh;
    ready_i = bp ? pat[0][0] : 1'b1;
    @(negedge clk);
    chk("clr_after_E0", int'(mac_clr_o), 1);
    chk("busy_after_E0", int'(busy_o), 1);
    chk("valid_after_E0", int'(valid_o), 0);
    @(posedge clk); #1;
    ready_i = bp ? pat[1][0] : 1'b1;
    @(negedge clk);
    chk("clr_after_E1", int'(mac_clr_o), 0);
    chk("valid_after_E1", int'(valid_o), 1);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      if (done_o) begin
        seen = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        ready_i = bp ? pat[cyc % 6][0] : 1'b1;
        if (poke) start_i = (cyc >= 4);
        @(negedge clk);
      end
    end
    start_i = 1'b0;
    chk("done_seen", int'(seen), 1);
    chk("busy_at_done", int'(busy_o), 0);
    if (!bp) chk("done_edge", cyc, N + 1);
    @(posedge clk); #1;
    ready_i = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", int'(done_o), 0);
    chk("idle_valid", int'(valid_o), 0);
    chk("idle_busy", int'(busy_o), 0);
    chk("idle_clr", int'(mac_clr_o), 0);
    chk("sb_empty", sb_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(valid_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_clr"}, int'(mac_clr_o), 0);
    chk({tag, "_data"}, int'(data_o), 0);
    chk({tag, "_lane"}, int'(lane_o), 0);
    chk({tag, "_flags"}, int'({sat_o, last_o, done_o}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; shift_i = '0; acc_i = '0; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Basic requantize, shift 4.
    va = '{32'd1000, 32'hFFFF_FC18, 32'd7, 32'd0, 32'd8, 32'hFFFF_FFF8, 32'd2047, 32'hFFFF_F7F8};
    vd = '{63, -62, 0, 0, 1, 0, 127, -128};
    vs = '{0, 0, 0, 0, 0, 0, 1, 0};
    push_exp();
    run_drain(5'd4, 1'b0, 1'b0);

    // Saturation, shift 0.
    va = '{32'd200, 32'hFFFE_EE90, 32'd127, 32'hFFFF_FF80, 32'd128, 32'hFFFF_FF7F, 32'd0, 32'hFFFF_FFFF};
    vd = '{127, -128, 127, -128, 127, -128, 0, -1};
    vs = '{1, 1, 0, 0, 1, 1, 0, 0};
    push_exp();
    run_drain(5'd0, 1'b0, 1'b0);

    // Rounding, shift 1.
    va = '{32'd7, 32'hFFFF_FFF9, 32'd1, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 32'd254, 32'hFFFF_FF00};
    vd = '{4, -3, 1, 0, 2, -1, 127, -128};
    vs = '{0, 0, 0, 0, 0, 0, 0, 0};
    push_exp();
    run_drain(5'd1, 1'b0, 1'b0);

    // Rounding extremes, shift 31.
    va = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h4000_0000, 32'hC000_0000, 32'h3FFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    vd = '{1, -1, 0, 1, 0, 0, 0, 0};
    vs = '{0, 0, 0, 0, 0, 0, 0, 0};
    push_exp();
    run_drain(5'd31, 1'b0, 1'b0);

    // Backpressure with the shift-4 vectors.
    va = '{32'd1000, 32'hFFFF_FC18, 32'd7, 32'd0, 32'd8, 32'hFFFF_FFF8, 32'd2047, 32'hFFFF_F7F8};
    vd = '{63, -62, 0, 0, 1, 0, 127, -128};
    vs = '{0, 0, 0, 0, 0, 0, 1, 0};
    push_exp();
    run_drain(5'd4, 1'b1, 1'b0);

    // Start held high mid-drain through the final handshake is ignored.
    va = '{32'd200, 32'hFFFE_EE90, 32'd127, 32'hFFFF_FF80, 32'd128, 32'hFFFF_FF7F, 32'd0, 32'hFFFF_FFFF};
    vd = '{127, -128, 127, -128, 127, -128, 0, -1};
    vs = '{1, 1, 0, 0, 1, 1, 0, 0};
    push_exp();
    run_drain(5'd0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("no_restart_valid", int'(valid_o), 0);
    chk("no_restart_busy", int'(busy_o), 0);

    // Reset mid-drain after two accepted beats.
    va = '{32'd7, 32'hFFFF_FFF9, 32'd1, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 32'd254, 32'hFFFF_FF00};
    vd = '{4, -3, 1, 0, 2, -1, 127, -128};
    vs = '{0, 0, 0, 0, 0, 0, 0, 0};
    push_exp();
    @(posedge clk); #1;
    load_acc();
    shift_i = 5'd1;
    start_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_zero("async_rst");
    chk("beats_before_rst", sb_q.size(), N - 2);
    sb_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", int'(done_o), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Fresh full drain after reset.
    va = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h4000_0000, 32'hC000_0000, 32'h3FFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    vd = '{1, -1, 0, 1, 0, 0, 0, 0};
    vs = '{0, 0, 0, 0, 0, 0, 0, 0};
    push_exp();
    run_drain(5'd31, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_result_drain.md
# mac_result_drain

Drains a bank of N signed 32-bit MAC accumulators at the end of a tile and returns them to 8-bit operand form as a ready/valid stream. On a start pulse it snapshots all lanes and pulses a clear back to the MAC bank so the next tile can begin. It then requantizes each lane (rounding arithmetic right shift, then saturation to int8) and emits one byte per beat. It sits between the MAC array and the operand/result buffer, closing the int8 → int32 → int8 loop.

## Interface
- N, 8, number of accumulator lanes (N ≥ 2)
- ACC_W, 32, accumulator width (two's complement)
- OUT_W, 8, output width (signed, saturated)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high; clk is the single clock
- start_i  in  1  drain request; sampled only in IDLE
- shift_i  in  5  right-shift amount 0..31; latched with start_i
- acc_i  in  N*ACC_W  accumulators, lane k at bits [k*ACC_W +: ACC_W]
- mac_clr_o  out  1  one-cycle registered clear to the MAC bank
- busy_o  out  1  high from the cycle after start acceptance until the final handshake
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accept
- data_o  out  OUT_W  requantized lane value
- sat_o  out  1  this beat was clamped
- lane_o  out  $clog2(N)  lane index of the current beat
- last_o  out  1  current beat is lane N-1
- done_o  out  1  one-cycle pulse after the final handshake

## Operation
- FSM states: IDLE, PREP, SEND.
- IDLE + start_i at edge E0:
  - shadow[0..N-1] <= acc_i
  - shift_q <= shift_i
  - idx <= 0
  - mac_clr_o <= 1
  - busy_o <= 1
  - state <= PREP
- PREP, at edge E1:
  - data_o/sat_o <= Q(shadow[0])
  - lane_o <= 0
  - last_o <= (N-1 == 0)
  - valid_o <= 1
  - mac_clr_o <= 0
  - state <= SEND
- SEND, valid_o && ready_i:
  - idx < N-1: idx++, load Q(shadow[idx+1]) into the output registers, valid_o stays 1 (no bubble).
  - idx == N-1: valid_o <= 0, busy_o <= 0, last_o <= 0, done_o <= 1 for one cycle, state <= IDLE.
- SEND, valid_o && !ready_i: data_o, sat_o, lane_o and last_o hold stable.
- Q(x): requantize function.
  - s = shift_q.
  - If s == 0: r = x.
  - Else: r = (sext33(x) + 2^(s-1)) >>> s. The add is 33-bit so it cannot overflow; this is round-half-up.
  - If r > 127: data = 127, sat = 1.
  - If r < -128: data = -128, sat = 1.
  - Otherwise data = r[7:0], sat = 0.
- Shadow registers decouple the drain from the MAC bank. acc_i may change freely after E0.

## Timing
- Reset values: state IDLE; mac_clr_o, busy_o, valid_o, sat_o, last_o, done_o = 0; data_o, lane_o = 0; shadow contents don't-care.
- Assertion of rst takes effect immediately, including mid-drain. Outputs drop within the cycle and no done_o pulse is produced.
- start_i high at E0 gives:
  - mac_clr_o high for exactly cycle E0..E1
  - first valid_o from E1
- With ready_i held high, lane k is accepted at edge E(2+k). The final handshake is at E(N+1), and done_o is high during E(N+1)..E(N+2).
- start_i is ignored while busy_o = 1, including the cycle of the final handshake. The earliest re-accept is the edge after done_o rises.
- ready_i may be high before valid_o. No combinational path from ready_i to any output.
- valid_o never drops without a handshake.

## Test plan
- Basic requantize, N=4, shift=4, acc = {1000, -1000, 7, 0}, ready=1:
  - Beats: 63, -62, 0, 0; all sat=0.
  - lane_o = 0..3; last_o only on lane 3.
  - mac_clr_o exactly one cycle after start; done_o one cycle after beat 3.
- Saturation with shift=0, acc = {200, -70000, 127, -128}:
  - Beats: 127 sat=1, -128 sat=1, 127 sat=0, -128 sat=0.
- Rounding edges:
  - shift=1, acc=7: 4
  - shift=1, acc=-7: -3
  - shift=31, acc=0x7FFFFFFF: 1
  - shift=31, acc=0x80000000: -1
- Backpressure, ready pattern 1,0,0,1,0,1,...: each beat's data/lane held stable while ready=0; exactly N beats total, no duplicates or drops.
- Start while busy: a second start mid-drain is ignored. Change acc_i after E0: emitted values still match the snapshot.
- Reset mid-drain after 2 of 8 beats: outputs return to 0 immediately, no done_o. A new start then drains all 8 lanes from lane 0.
